// File: rtl/state_dump_unit_pkg.sv
// Shared constants for the state dump unit: word widths, output tags and FSM encodings.
package state_dump_unit_pkg;

   localparam int XLEN_32b = 32;
   localparam int XLEN_64b = 64;
   localparam int REG_CNT_DEF = 32;

   localparam logic [1:0] DUMP_TAG_TS  = 2'd0;
   localparam logic [1:0] DUMP_TAG_SEQ = 2'd1;
   localparam logic [1:0] DUMP_TAG_REG = 2'd2;
   localparam logic [1:0] DUMP_TAG_MEM = 2'd3;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR_TS  = 3'd1;
   localparam logic [2:0] ST_HDR_SEQ = 3'd2;
   localparam logic [2:0] ST_REG_REQ = 3'd3;
   localparam logic [2:0] ST_REG_CAP = 3'd4;
   localparam logic [2:0] ST_MEM_REQ = 3'd5;
   localparam logic [2:0] ST_MEM_CAP = 3'd6;

   // Tag presented on the stream for a given state; non-emitting states report 0.
   function automatic logic [1:0] tag_for_state(input logic [2:0] st);
      case (st)
         ST_HDR_SEQ: return DUMP_TAG_SEQ;
         ST_REG_CAP: return DUMP_TAG_REG;
         ST_MEM_CAP: return DUMP_TAG_MEM;
         default:    return DUMP_TAG_TS;
      endcase
   endfunction

endpackage

// File: rtl/state_dump_unit_trigger.sv
// Dump start qualification: periodic tick generator, trigger merge and saturating drop counter.
module dump_trigger_gen
   import state_dump_unit_pkg::*;
#(
   parameter int PERIOD = 2000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_mode,
   input  logic       i_trigger,
   input  logic       i_idle,
   output logic       o_start,
   output logic [7:0] o_missed
);

   localparam int PC_W = $clog2(PERIOD);

   logic [PC_W-1:0] period_cnt;
   logic            period_tick;
   logic            start_req;

   assign period_tick = i_mode && (period_cnt == PC_W'(PERIOD - 1));
   // A trigger coincident with a tick is one request, not two.
   assign start_req   = (i_trigger || period_tick) && i_enable;
   assign o_start     = start_req && i_idle;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         period_cnt <= '0;
         o_missed   <= '0;
      end else begin
         if (!i_mode || period_tick)
            period_cnt <= '0;
         else
            period_cnt <= period_cnt + PC_W'(1);

         if (start_req && !i_idle && (o_missed != 8'hFF))
            o_missed <= o_missed + 8'd1;
      end
   end

endmodule

// File: rtl/state_dump_unit.sv
// Snapshots the register file and a data-memory window and streams it as tagged words.
//
// state      | meaning
// IDLE       | waiting for a qualified start
// HDR_TS     | presenting latched timestamp header
// HDR_SEQ    | presenting sequence number header
// REG_REQ    | read strobe to register debug port for index k
// REG_CAP    | presenting register k, held until accepted
// MEM_REQ    | read strobe to memory debug port for word j
// MEM_CAP    | presenting memory word j, held until accepted
module state_dump_unit
   import state_dump_unit_pkg::*;
#(
   parameter int XLEN      = XLEN_32b,
   parameter int REG_CNT   = REG_CNT_DEF,
   parameter int MEM_WORDS = 32,
   parameter int ADDR_W    = 32,
   parameter int PERIOD    = 2000,
   parameter int TS_W      = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_enable,
   input  logic                       i_mode,
   input  logic                       i_trigger,
   input  logic [ADDR_W-1:0]          i_mem_base,
   output logic                       o_reg_rd_en,
   output logic [$clog2(REG_CNT)-1:0] o_reg_rd_idx,
   input  logic [XLEN-1:0]            i_reg_rd_data,
   output logic                       o_mem_rd_en,
   output logic [ADDR_W-1:0]          o_mem_rd_addr,
   input  logic [XLEN-1:0]            i_mem_rd_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [XLEN-1:0]            o_data,
   output logic [1:0]                 o_tag,
   output logic [15:0]                o_index,
   output logic                       o_last,
   output logic                       o_busy,
   output logic [7:0]                 o_missed
);

   localparam int RI_W    = $clog2(REG_CNT);
   localparam int MI_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int BYTES   = XLEN / 8;
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(BYTES - 1));

   logic [2:0]        state;
   logic [RI_W-1:0]   reg_idx;
   logic [MI_W-1:0]   mem_idx;
   logic [ADDR_W-1:0] mem_addr;
   logic [TS_W-1:0]   ts_cnt;
   logic [TS_W-1:0]   ts_lat;
   logic [15:0]       seq_cnt;
   logic [XLEN-1:0]   cap_data;
   logic              cap_fresh;
   logic              idle;
   logic              dump_start;
   logic [XLEN-1:0]   word_data;

   assign idle   = (state == ST_IDLE);
   assign o_busy = !idle;

   dump_trigger_gen #(
      .PERIOD (PERIOD)
   ) u_trigger (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_enable  (i_enable),
      .i_mode    (i_mode),
      .i_trigger (i_trigger),
      .i_idle    (idle),
      .o_start   (dump_start),
      .o_missed  (o_missed)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         reg_idx   <= '0;
         mem_idx   <= '0;
         mem_addr  <= '0;
         ts_cnt    <= '0;
         ts_lat    <= '0;
         seq_cnt   <= '0;
         cap_data  <= '0;
         cap_fresh <= 1'b0;
      end else begin
         ts_cnt    <= ts_cnt + TS_W'(1);
         cap_fresh <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (dump_start) begin
                  state    <= ST_HDR_TS;
                  ts_lat   <= ts_cnt;
                  mem_addr <= i_mem_base & ADDR_MASK;
                  reg_idx  <= '0;
                  mem_idx  <= '0;
               end
            end
            ST_HDR_TS: if (i_ready) state <= ST_HDR_SEQ;
            ST_HDR_SEQ: if (i_ready) state <= ST_REG_REQ;
            ST_REG_REQ: begin
               state     <= ST_REG_CAP;
               cap_fresh <= 1'b1;
            end
            ST_REG_CAP: begin
               if (cap_fresh) cap_data <= i_reg_rd_data;
               if (i_ready) begin
                  if (reg_idx == RI_W'(REG_CNT - 1)) begin
                     state   <= ST_MEM_REQ;
                     reg_idx <= '0;
                  end else begin
                     state   <= ST_REG_REQ;
                     reg_idx <= reg_idx + RI_W'(1);
                  end
               end
            end
            ST_MEM_REQ: begin
               state     <= ST_MEM_CAP;
               cap_fresh <= 1'b1;
            end
            ST_MEM_CAP: begin
               if (cap_fresh) cap_data <= i_mem_rd_data;
               if (i_ready) begin
                  if (mem_idx == MI_W'(MEM_WORDS - 1)) begin
                     state   <= ST_IDLE;
                     mem_idx <= '0;
                     seq_cnt <= seq_cnt + 16'd1;
                  end else begin
                     state    <= ST_MEM_REQ;
                     mem_idx  <= mem_idx + MI_W'(1);
                     mem_addr <= mem_addr + ADDR_W'(BYTES);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read data arrives in the first capture cycle; pass it straight through, then hold the copy.
   always_comb begin
      word_data = cap_data;
      if (cap_fresh)
         word_data = (state == ST_REG_CAP) ? i_reg_rd_data : i_mem_rd_data;
   end

   always_comb begin
      o_valid = 1'b0;
      o_data  = '0;
      o_index = '0;
      case (state)
         ST_HDR_TS: begin
            o_valid = 1'b1;
            o_data  = XLEN'(ts_lat);
         end
         ST_HDR_SEQ: begin
            o_valid = 1'b1;
            o_data  = XLEN'(seq_cnt);
         end
         ST_REG_CAP: begin
            o_valid = 1'b1;
            o_data  = word_data;
            o_index = 16'(reg_idx);
         end
         ST_MEM_CAP: begin
            o_valid = 1'b1;
            o_data  = word_data;
            o_index = 16'(mem_idx);
         end
         default: ;
      endcase
   end

   assign o_tag         = tag_for_state(state);
   assign o_last        = (state == ST_MEM_CAP) && (mem_idx == MI_W'(MEM_WORDS - 1));
   assign o_reg_rd_en   = (state == ST_REG_REQ);
   assign o_reg_rd_idx  = o_reg_rd_en ? reg_idx : '0;
   assign o_mem_rd_en   = (state == ST_MEM_REQ);
   assign o_mem_rd_addr = o_mem_rd_en ? mem_addr : '0;

endmodule
